// File: rtl/cpu_skid_fifo_pkg.sv
// Shared CPU pipeline defines for the skid FIFO: count-width helper and
// the legality rule for the DEPTH parameter.
package cpu_skid_fifo_pkg;

   // Width needed to hold a count from 0 up to and including depth.
   function automatic int cw_of(input int depth);
      return $clog2(depth + 1);
   endfunction

   // DEPTH must be a power of two no smaller than 2 so pointers wrap for free.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/cpu_skid_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately unreset; the top masks empty reads.
module cpu_skid_fifo_mem #(
   parameter int DW    = 32,
   parameter int DEPTH = 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Store the incoming word at the write pointer.
   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_skid_fifo.sv
// Valid/ready skid FIFO between CPU pipeline stages. Holds up to DEPTH
// words; REG_OUT=0 passes a word straight through when empty, REG_OUT=1
// always presents the output from storage. i_flush drops everything held.
module cpu_skid_fifo
   import cpu_skid_fifo_pkg::*;
#(
   parameter int DW      = 32,
   parameter int DEPTH   = 2,
   parameter int REG_OUT = 0
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_flush,
   input  logic                      i_valid,
   input  logic [DW-1:0]             i_data,
   output logic                      o_ready,
   output logic                      o_valid,
   output logic [DW-1:0]             o_data,
   input  logic                      i_ready,
   output logic [cw_of(DEPTH)-1:0]   o_count
);

   localparam int CW = cw_of(DEPTH);
   localparam int PW = $clog2(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("cpu_skid_fifo: DEPTH must be a power of two and >= 2");
   end

   logic [PW-1:0] rp;
   logic [PW-1:0] wp;
   logic [CW-1:0] count;
   logic [DW-1:0] head;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          bypass;
   logic          do_push;
   logic          do_pop;
   logic          wr_en;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Handshake and data presentation; ready comes only from registered state.
   always_comb begin
      o_ready = !full;
      o_valid = (REG_OUT != 0) ? !empty : (!empty || i_valid);
      o_data  = '0;
      if (!empty) begin
         o_data = head;
      end else if ((REG_OUT == 0) && i_valid) begin
         o_data = i_data;
      end
   end

   assign push    = i_valid && o_ready;
   assign pop     = o_valid && i_ready;
   // An empty bypass transfer never touches storage or pointers.
   assign bypass  = (REG_OUT == 0) && empty && push && pop;
   assign do_push = push && !bypass;
   assign do_pop  = pop && !bypass;
   assign wr_en   = do_push && i_reset && !i_flush;
   assign o_count = count;

   cpu_skid_fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .i_clock (i_clock),
      .wr_en   (wr_en),
      .wr_addr (wp),
      .wr_data (i_data),
      .rd_addr (rp),
      .rd_data (head)
   );

   // Pointer and occupancy update: reset beats flush, flush beats transfers.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else if (i_flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wp <= wp + PW'(1);
         end
         if (do_pop) begin
            rp <= rp + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_skid_fifo.sv
// Directed bench for cpu_skid_fifo: two instances, A = DEPTH 2 bypass mode,
// B = DEPTH 4 registered mode. Inputs change on the falling edge and outputs
// are checked just after, before the next rising edge.
module tb_cpu_skid_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DEPTH=2, REG_OUT=0
   logic        a_rst, a_flush, a_valid, a_ready;
   logic [15:0] a_data;
   logic        a_o_ready, a_o_valid;
   logic [15:0] a_o_data;
   logic [1:0]  a_count;

   // Instance B: DEPTH=4, REG_OUT=1
   logic        b_rst, b_flush, b_valid, b_ready;
   logic [15:0] b_data;
   logic        b_o_ready, b_o_valid;
   logic [15:0] b_o_data;
   logic [2:0]  b_count;

   cpu_skid_fifo #(.DW(16), .DEPTH(2), .REG_OUT(0)) u_a (
      .i_clock (clk),
      .i_reset (a_rst),
      .i_flush (a_flush),
      .i_valid (a_valid),
      .i_data  (a_data),
      .o_ready (a_o_ready),
      .o_valid (a_o_valid),
      .o_data  (a_o_data),
      .i_ready (a_ready),
      .o_count (a_count)
   );

   cpu_skid_fifo #(.DW(16), .DEPTH(4), .REG_OUT(1)) u_b (
      .i_clock (clk),
      .i_reset (b_rst),
      .i_flush (b_flush),
      .i_valid (b_valid),
      .i_data  (b_data),
      .o_ready (b_o_ready),
      .o_valid (b_o_valid),
      .o_data  (b_o_data),
      .i_ready (b_ready),
      .o_count (b_count)
   );

   typedef struct {
      bit          dut;    // 0 = A, 1 = B
      bit          rst_n;
      bit          flush;
      bit          valid;
      logic [15:0] data;
      bit          ready;
      bit          ev;     // expected o_valid
      logic [15:0] ed;     // expected o_data
      bit          er;     // expected o_ready
      logic [2:0]  ec;     // expected o_count
   } vec_t;

   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t tbl[$];

   function automatic vec_t mk(bit dut, bit rst_n, bit flush, bit valid, logic [15:0] data,
                               bit ready, bit ev, logic [15:0] ed, bit er, logic [2:0] ec);
      vec_t v;
      v.dut = dut; v.rst_n = rst_n; v.flush = flush; v.valid = valid; v.data = data;
      v.ready = ready; v.ev = ev; v.ed = ed; v.er = er; v.ec = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      a_rst = 1'b1; a_flush = 1'b0; a_valid = 1'b0; a_data = '0; a_ready = 1'b0;
      b_rst = 1'b1; b_flush = 1'b0; b_valid = 1'b0; b_data = '0; b_ready = 1'b0;
   endtask

   // Drive one cycle on the selected instance and check its outputs pre-edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      idle_all();
      if (v.dut) begin
         b_rst = v.rst_n; b_flush = v.flush; b_valid = v.valid; b_data = v.data; b_ready = v.ready;
      end else begin
         a_rst = v.rst_n; a_flush = v.flush; a_valid = v.valid; a_data = v.data; a_ready = v.ready;
      end
      #2;
      n_vec++;
      if (v.dut) begin
         chk({tag, ".valid"}, 16'(b_o_valid), 16'(v.ev));
         chk({tag, ".data"},  b_o_data,        v.ed);
         chk({tag, ".ready"}, 16'(b_o_ready), 16'(v.er));
         chk({tag, ".count"}, 16'(b_count),   16'(v.ec));
      end else begin
         chk({tag, ".valid"}, 16'(a_o_valid), 16'(v.ev));
         chk({tag, ".data"},  a_o_data,        v.ed);
         chk({tag, ".ready"}, 16'(a_o_ready), 16'(v.er));
         chk({tag, ".count"}, 16'(a_count),   16'(v.ec));
      end
   endtask

   initial begin
      int p;
      int k;
      bit done;

      idle_all();
      a_rst = 1'b0;
      b_rst = 1'b0;
      // first rising edge at t=5 resets both instances

      // reset held 3 cycles on B with traffic on the input
      tbl.push_back(mk(1, 0, 0, 1, 16'hDEAD, 0, 0, 16'h0, 1, 3'd0));
      tbl.push_back(mk(1, 0, 0, 1, 16'hDEAD, 0, 0, 16'h0, 1, 3'd0));
      tbl.push_back(mk(1, 0, 0, 1, 16'hDEAD, 0, 0, 16'h0, 1, 3'd0));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0, 1, 3'd0));
      // bypass on A: each word visible in its own push cycle, count stays 0
      tbl.push_back(mk(0, 1, 0, 1, 16'h0011, 1, 1, 16'h11, 1, 3'd0));
      tbl.push_back(mk(0, 1, 0, 1, 16'h0022, 1, 1, 16'h22, 1, 3'd0));
      tbl.push_back(mk(0, 1, 0, 1, 16'h0033, 1, 1, 16'h33, 1, 3'd0));
      tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0));
      // fill and stall on B: 1..4 accepted, 5 and 6 refused
      tbl.push_back(mk(1, 1, 0, 1, 16'h0001, 0, 0, 16'h0, 1, 3'd0));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0002, 0, 1, 16'h1, 1, 3'd1));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0003, 0, 1, 16'h1, 1, 3'd2));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0004, 0, 1, 16'h1, 1, 3'd3));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0005, 0, 1, 16'h1, 0, 3'd4));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0006, 0, 1, 16'h1, 0, 3'd4));
      // drain: 1,2,3,4 one per cycle, ready rises the cycle after the first pop
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h1, 0, 3'd4));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h2, 1, 3'd3));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h3, 1, 3'd2));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h4, 1, 3'd1));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h0, 1, 3'd0));
      // full with simultaneous pop on B
      tbl.push_back(mk(1, 1, 0, 1, 16'h0041, 0, 0, 16'h00, 1, 3'd0));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0042, 0, 1, 16'h41, 1, 3'd1));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0043, 0, 1, 16'h41, 1, 3'd2));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0044, 0, 1, 16'h41, 1, 3'd3));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0045, 1, 1, 16'h41, 0, 3'd4));
      tbl.push_back(mk(1, 1, 0, 1, 16'h0046, 1, 1, 16'h42, 1, 3'd3));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h43, 1, 3'd3));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h44, 1, 3'd2));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h46, 1, 3'd1));
      tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0));

      foreach (tbl[i]) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // flush on B at count=3 together with a push of 0x99
      apply(mk(1, 1, 0, 1, 16'h0071, 0, 0, 16'h00, 1, 3'd0), "flush.fill0");
      apply(mk(1, 1, 0, 1, 16'h0072, 0, 1, 16'h71, 1, 3'd1), "flush.fill1");
      apply(mk(1, 1, 0, 1, 16'h0073, 0, 1, 16'h71, 1, 3'd2), "flush.fill2");
      apply(mk(1, 1, 1, 1, 16'h0099, 0, 1, 16'h71, 1, 3'd3), "flush.edge");
      apply(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0), "flush.after0");
      apply(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0), "flush.after1");
      apply(mk(1, 1, 0, 1, 16'h0055, 1, 0, 16'h00, 1, 3'd0), "flush.push");
      apply(mk(1, 1, 0, 0, 16'h0000, 1, 1, 16'h55, 1, 3'd1), "flush.pop");

      // reset mid-operation on B discards held words
      apply(mk(1, 1, 0, 1, 16'h0061, 0, 0, 16'h00, 1, 3'd0), "midrst.fill");
      apply(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h61, 1, 3'd1), "midrst.edge");
      apply(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0), "midrst.after");

      // wrap-around on A: 10 words, downstream ready toggling 1,0,1,0...
      p = 0;
      k = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 80 && !done; cyc++) begin
         @(negedge clk);
         idle_all();
         a_valid = (k < 10);
         a_data  = 16'(16'hA0 + k);
         a_ready = (cyc % 2 == 0);
         #2;
         if (a_o_valid && a_ready) begin
            chk($sformatf("wrap.word%0d", p), a_o_data, 16'(16'hA0 + p));
            p++;
         end
         if (a_valid && a_o_ready) begin
            k++;
         end
         if (p >= 10) begin
            done = 1'b1;
         end
      end
      chk("wrap.words_out", 16'(p), 16'd10);
      n_vec++;
      apply(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h00, 1, 3'd0), "wrap.idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_skid_fifo.md
# cpu_skid_fifo

Parametrised valid/ready skid buffer, the successor to the single-register stall-driven skid stage used between CPU pipeline stages. It replaces the global `busy` stall with a per-stage valid/ready handshake and holds up to DEPTH words, so an upstream stage can run one or more cycles ahead of a stalled downstream stage without losing data. Two modes are provided:

- **Bypass mode:** zero-latency combinational pass-through when empty.
- **Registered mode:** fully registered output, which breaks timing paths between stages.

Flush support lets the pipeline discard in-flight words on branch mispredict or trap.

## Interface

Parameters:
- `DW`, default 32: data width in bits; must be ≥ 1.
- `DEPTH`, default 2: storage entries; must be a power of two and ≥ 2.
- `REG_OUT`, default 0:
  - 0 = bypass when empty;
  - 1 = output always taken from storage.

Ports:
- `i_clock`  in  1: single clock, rising edge.
- `i_reset`  in  1: reset, synchronous and active-low (0 = reset).
- `i_flush`  in  1: discard all stored words at the next edge.
- `i_valid`  in  1: upstream word present.
- `i_data`  in  DW: upstream word.
- `o_ready`  out  1: buffer accepts a word this cycle.
- `o_valid`  out  1: word presented downstream.
- `o_data`  out  DW: downstream word; 0 when `o_valid`=0.
- `i_ready`  in  1: downstream accepts the word this cycle.
- `o_count`  out  CW: stored entries, 0..DEPTH, where CW = $clog2(DEPTH+1).

## Operation

Transfer rules:
- Push occurs when `i_valid` && `o_ready`.
- Pop occurs when `o_valid` && `i_ready`.

Storage:
- Circular buffer with read pointer `rp` and write pointer `wp`, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
- `count` is tracked separately; full = (`count` == DEPTH), empty = (`count` == 0).

Handshake outputs:
- `o_ready` = !full. It is registered-state derived and never depends on `i_ready` or `i_valid` (no combinational ready path upstream).
- `o_valid` depends on mode:
  - REG_OUT=0: !empty || `i_valid`.
  - REG_OUT=1: !empty.
- `o_data` depends on state and mode:
  - !empty: head entry `mem[rp]`.
  - Empty with REG_OUT=0 and `i_valid`: `i_data` (bypass).
  - Otherwise: 0.

Bypass (REG_OUT=0, empty, push and pop in the same cycle):
- The word passes through and is not written.
- `count`, `wp` and `rp` are unchanged.

Simultaneous push and pop (non-empty):
- Write `mem[wp]`, advance both pointers, `count` unchanged.

Full:
- `o_ready`=0, so no push can occur.
- A pop in the full cycle frees one slot; `o_ready` rises on the next cycle, not the same cycle.

Flush (`i_flush`=1):
- At the edge, `rp`, `wp` and `count` are set to 0.
- Any push or pop in that cycle is ignored for state purposes; a push in that cycle is dropped.
- Outputs during the flush cycle still follow the pre-edge state.

Reset and priority:
- Reset has priority over flush; flush has priority over push/pop.
- Storage array contents are not reset; they are unobservable because `o_data` is forced to 0 when empty.

## Timing

- Reset (`i_reset`=0 at an edge): `count`=0, `rp`=`wp`=0.
- Outputs after reset: `o_valid`=0, `o_data`=0, `o_count`=0, `o_ready`=1 from the first cycle after the reset edge.
- Reset asserted mid-operation discards all stored words at that edge.
- Latency with REG_OUT=0: 0 cycles when empty and downstream ready; otherwise 1 cycle per queued word ahead.
- Latency with REG_OUT=1: minimum 1 cycle. A word pushed at edge N is visible on `o_valid`/`o_data` after edge N.
- Throughput: 1 word/cycle sustained in both modes while `i_ready`=1.
- `o_count` updates one cycle after the transfer that changed it.
- Words leave strictly in FIFO order; none are duplicated or lost except by flush or reset.

## Structure

- Shared package (`CPU_Defines`) holds:
  - a `CW` helper constant/function, $clog2(DEPTH+1);
  - the elaboration-time assertion rule that DEPTH is a power of two ≥ 2.
- One sub-module: `cpu_skid_mem`. It is a DEPTH×DW register array with one synchronous write port and one asynchronous read port, unreset.
- The top level holds pointers, `count`, the mode muxing and the handshake logic.

## Test plan

- **Reset:** hold `i_reset`=0 for 3 cycles while driving `i_valid`=1, `i_data`=0xDEAD. Required: `o_valid`=0, `o_count`=0 throughout; `o_ready`=1 on the first cycle after release.
- **Bypass (REG_OUT=0, DEPTH=2):** with `i_ready`=1, push 0x11, 0x22, 0x33 on consecutive cycles. Required: each word appears on `o_data` in its own push cycle; `o_count` stays 0.
- **Fill and stall (DEPTH=4, REG_OUT=1):** hold `i_ready`=0 and push 0x1..0x6. Required:
  - 0x1–0x4 accepted; `o_ready` drops after the 4th push; `o_count`=4.
  - Releasing `i_ready` yields 0x1, 0x2, 0x3, 0x4 in order, one per cycle.
- **Wrap-around (DEPTH=2):** run 10 words with `i_ready` toggling 1,0,1,0… Required: output sequence equals input sequence and pointers wrap without loss.
- **Flush:** with `count`=3 (DEPTH=4), assert `i_flush` together with a push of 0x99. Required: next cycle `o_valid`=0, `o_count`=0, `o_ready`=1, and 0x99 is never output.
- **Full with simultaneous pop:** at `count`=DEPTH, set `i_ready`=1 and `i_valid`=1. Required: `o_ready`=0 in that cycle, `o_count`=DEPTH-1 next cycle with `o_ready`=1, then a push and a pop in the same cycle keep `o_count` constant.
